// File: rtl/union_word_tx.sv
// union_word_tx: transmit side of the tagged-union word link.
// Accepts a 32-bit word plus a member tag, holds it in a union register and
// sends a frame: header {HDR_MAGIC, 2'b00, tag}, then payload bytes LSB first.
// Optional checksum byte (XOR of header and payload) when the macro
// UNION_WORD_TX_CHECKSUM_EN is defined.
module union_word_tx #(
  parameter logic [3:0]  HDR_MAGIC     = 4'hA,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_tag,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err_illegal,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  localparam logic [1:0] TAG_INT   = 2'd0;
  localparam logic [1:0] TAG_SREAL = 2'd1;
  localparam logic [1:0] TAG_RAW   = 2'd2;

`ifdef UNION_WORD_TX_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CHK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;
`endif

  // All members alias the same 32 bits; shortreal is carried as its bit image
  // so the register stays synthesizable.
  typedef union packed {
    logic signed [31:0] as_int;
    logic [31:0]        as_sreal_bits;
    logic [31:0]        as_raw;
  } word_u;

  state_t           state, state_nxt;
  word_u            word, word_nxt;
  logic [1:0]       tag, tag_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             err_nxt;
  logic             valid_nxt;
  logic [7:0]       data_nxt;
  logic             last_nxt;
  logic [7:0]       hdr_nxt;

`ifdef UNION_WORD_TX_CHECKSUM_EN
  logic [7:0]       chk_nxt;

  // Checksum over the header and every transmitted payload byte.
  always_comb begin
    chk_nxt = hdr_nxt;
    for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
      chk_nxt = chk_nxt ^ word_nxt.as_raw[8*i +: 8];
    end
  end
`endif

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    tag_nxt   = tag;
    idx_nxt   = idx;
    count_nxt = frame_count;
    err_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          if (in_tag != 2'd3) begin
            case (in_tag)
              TAG_INT:   word_nxt.as_int        = in_data;
              TAG_SREAL: word_nxt.as_sreal_bits = in_data;
              TAG_RAW:   word_nxt.as_raw        = in_data;
              default:   word_nxt.as_raw        = in_data;
            endcase
            tag_nxt   = in_tag;
            state_nxt = S_HDR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (out_ready) begin
          idx_nxt   = '0;
          state_nxt = S_PAY;
        end
      end
      S_PAY: begin
        if (out_ready) begin
          if (idx == LAST_IDX) begin
`ifdef UNION_WORD_TX_CHECKSUM_EN
            state_nxt = S_CHK;
`else
            count_nxt = frame_count + CNT_W'(1);
            idx_nxt   = '0;
            state_nxt = S_IDLE;
`endif
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
`ifdef UNION_WORD_TX_CHECKSUM_EN
      S_CHK: begin
        if (out_ready) begin
          count_nxt = frame_count + CNT_W'(1);
          idx_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    hdr_nxt   = {HDR_MAGIC, 2'b00, tag_nxt};
    valid_nxt = (state_nxt != S_IDLE);
    data_nxt  = 8'h00;
    last_nxt  = 1'b0;
    case (state_nxt)
      S_HDR: data_nxt = hdr_nxt;
      S_PAY: begin
        data_nxt = word_nxt.as_raw[{idx_nxt, 3'b000} +: 8];
`ifndef UNION_WORD_TX_CHECKSUM_EN
        last_nxt = (idx_nxt == LAST_IDX);
`endif
      end
`ifdef UNION_WORD_TX_CHECKSUM_EN
      S_CHK: begin
        data_nxt = chk_nxt;
        last_nxt = 1'b1;
      end
`endif
      default: data_nxt = 8'h00;
    endcase
  end

  // State, datapath and registered outputs; synchronous reset abandons a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      word        <= '0;
      tag         <= '0;
      idx         <= '0;
      frame_count <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      state       <= state_nxt;
      word        <= word_nxt;
      tag         <= tag_nxt;
      idx         <= idx_nxt;
      frame_count <= count_nxt;
      in_ready    <= (state_nxt == S_IDLE);
      out_valid   <= valid_nxt;
      out_data    <= data_nxt;
      out_last    <= last_nxt;
      busy        <= (state_nxt != S_IDLE);
      err_illegal <= err_nxt;
    end
  end

endmodule

// File: tb/tb_union_word_tx.sv
// Directed, table-driven bench for union_word_tx (default build, no checksum).
// The frame counter is instantiated narrow so its wrap point is reachable.
module tb_union_word_tx;

  localparam int unsigned TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_tag;
  logic [31:0]         in_data;
  logic                out_valid;
  logic                out_ready;
  logic [7:0]          out_data;
  logic                out_last;
  logic                busy;
  logic                err_illegal;
  logic [TB_CNT_W-1:0] frame_count;

  int checks = 0;
  int errors = 0;
  logic [TB_CNT_W-1:0] exp_cnt;

  union_word_tx #(
    .HDR_MAGIC    (4'hA),
    .PAYLOAD_BYTES(4),
    .CNT_W        (TB_CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tag     (in_tag),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .err_illegal(err_illegal),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       tag;
    logic [31:0]      data;
    bit               stall;
    logic [0:4][7:0]  exp;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one word, then collect and check its frame with an optional 1,0,0 ready pattern.
  task automatic send_frame(input logic [1:0] tag, input logic [31:0] data,
                            input bit stall, input logic [0:4][7:0] exp);
    int   k = 0;
    int   cyc = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] pd = 8'h00;
    @(negedge clk);
    chk("in_ready_before", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_tag    = tag;
    in_data   = data;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("hdr_latency_valid", 32'(out_valid), 32'd1);
    while (k < 5 && cyc < 60) begin
      chk("valid_held", 32'(out_valid), 32'd1);
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("in_ready_low", 32'(in_ready), 32'd0);
      if (pv && !pr) begin
        chk("stall_data_stable", 32'(out_data), 32'(pd));
        chk("stall_last_stable", 32'(out_last), 32'(pl));
      end
      out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
      if (out_valid && out_ready) begin
        chk($sformatf("byte%0d", k), 32'(out_data), 32'(exp[k]));
        chk($sformatf("last%0d", k), 32'(out_last), (k == 4) ? 32'd1 : 32'd0);
        k++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      cyc++;
      @(negedge clk);
    end
    chk("frame_done_in_budget", 32'(k), 32'd5);
    out_ready = 1'b0;
    exp_cnt = exp_cnt + TB_CNT_W'(1);
    chk("in_ready_after", 32'(in_ready), 32'd1);
    chk("valid_after", 32'(out_valid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("frame_count", 32'(frame_count), 32'(exp_cnt));
  endtask

  initial begin
    vecs[0] = '{tag: 2'd0, data: 32'h12345678, stall: 1'b0, exp: {8'hA0, 8'h78, 8'h56, 8'h34, 8'h12}};
    vecs[1] = '{tag: 2'd1, data: 32'h3F800000, stall: 1'b1, exp: {8'hA1, 8'h00, 8'h00, 8'h80, 8'h3F}};
    vecs[2] = '{tag: 2'd2, data: 32'hCAFEF00D, stall: 1'b0, exp: {8'hA2, 8'h0D, 8'hF0, 8'hFE, 8'hCA}};
    vecs[3] = '{tag: 2'd0, data: 32'hFFFFFFFF, stall: 1'b1, exp: {8'hA0, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    vecs[4] = '{tag: 2'd2, data: 32'h00000001, stall: 1'b0, exp: {8'hA2, 8'h01, 8'h00, 8'h00, 8'h00}};

    rst = 1'b1; in_valid = 1'b0; in_tag = 2'd0; in_data = '0; out_ready = 1'b0;
    exp_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_illegal), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    rst = 1'b0;

    // Reset mid-frame, with an illegal word offered while busy.
    @(negedge clk);
    in_valid = 1'b1; in_tag = 2'd0; in_data = 32'h12345678;
    @(negedge clk);
    in_tag = 2'd3; in_data = 32'hDEADBEEF;
    chk("mid_hdr_valid", 32'(out_valid), 32'd1);
    chk("mid_hdr_data", 32'(out_data), 32'hA0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_illegal_no_err", 32'(err_illegal), 32'd0);
    chk("busy_hdr_held", 32'(out_data), 32'hA0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_pay0", 32'(out_data), 32'h78);
    @(negedge clk);
    chk("mid_pay1", 32'(out_data), 32'h56);
    @(negedge clk);
    chk("mid_pay2", 32'(out_data), 32'h34);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(frame_count), 32'(exp_cnt));
    @(negedge clk);
    chk("abort_no_more_bytes", 32'(out_valid), 32'd0);

    // Table of frames.
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].tag, vecs[i].data, vecs[i].stall, vecs[i].exp);
    end

    // Illegal tag in IDLE: one-cycle error pulse, nothing sent.
    @(negedge clk);
    in_valid = 1'b1; in_tag = 2'd3; in_data = 32'hDEADBEEF;
    @(negedge clk);
    in_valid = 1'b0;
    chk("illegal_err_pulse", 32'(err_illegal), 32'd1);
    chk("illegal_no_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("illegal_err_one_cycle", 32'(err_illegal), 32'd0);
    chk("illegal_no_valid2", 32'(out_valid), 32'd0);
    chk("illegal_count", 32'(frame_count), 32'(exp_cnt));
    chk("illegal_in_ready", 32'(in_ready), 32'd1);

    // Run the counter through its wrap point.
    while (exp_cnt != {TB_CNT_W{1'b1}}) begin
      send_frame(2'd1, 32'hA5A55A5A, 1'b0, {8'hA1, 8'h5A, 8'h5A, 8'hA5, 8'hA5});
    end
    chk("count_at_max", 32'(frame_count), 32'(4'hF));
    send_frame(2'd2, 32'hCAFEF00D, 1'b0, {8'hA2, 8'h0D, 8'hF0, 8'hFE, 8'hCA});
    chk("count_wrapped", 32'(frame_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
